// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants: datapath width, ALU opcodes, multiply sequencer states
package cpu_pkg;

    localparam int CPU_WIDTH = 19;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_NOT = 4'b0101;
    localparam logic [3:0] ALU_SHL = 4'b0110;
    localparam logic [3:0] ALU_SHR = 4'b0111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        SHL  = 2'd2,
        DONE = 2'd3
    } mul_state_e;

endpackage

// File: rtl/cpu_alu.sv
// rtl/cpu_alu.sv - combinational CPU ALU shared between the core and the multiply sequencer
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int WIDTH   = CPU_WIDTH,
    parameter int SHAMT_W = 5
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_XOR: y = a ^ b;
            ALU_NOT: y = ~a;
            ALU_SHL: y = a << b[SHAMT_W-1:0];
            ALU_SHR: y = a >> b[SHAMT_W-1:0];
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - shift-add unsigned multiplier that borrows the shared ALU for ADD/SHL
module alu_mul_seq
    import cpu_pkg::*;
#(
    parameter int WIDTH   = CPU_WIDTH,
    parameter int SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             start_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    output logic             alu_own,
    output logic [3:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_y
);

    localparam logic [SHAMT_W-1:0] SHIFT_ONE = SHAMT_W'(1);

    mul_state_e       state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mc;
    logic [WIDTH-1:0] mp;
    logic             ovf_r;
    logic [WIDTH-1:0] mp_shr;

    assign mp_shr = mp >> 1;

    // ALU lines must follow the current state in the same cycle, so they stay combinational.
    always_comb begin
        alu_own = 1'b0;
        alu_op  = ALU_ADD;
        alu_a   = '0;
        alu_b   = '0;
        case (state)
            ADD: begin
                if (mp[0]) begin
                    alu_own = 1'b1;
                    alu_op  = ALU_ADD;
                    alu_a   = acc;
                    alu_b   = mc;
                end
            end
            SHL: begin
                alu_own = 1'b1;
                alu_op  = ALU_SHL;
                alu_a   = mc;
                alu_b   = WIDTH'(SHIFT_ONE);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            acc         <= '0;
            mc          <= '0;
            mp          <= '0;
            ovf_r       <= 1'b0;
            start_ready <= 1'b1;
            res_valid   <= 1'b0;
            result      <= '0;
            ovf         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc         <= '0;
                        mc          <= op_a;
                        mp          <= op_b;
                        ovf_r       <= 1'b0;
                        start_ready <= 1'b0;
                        state       <= ADD;
                    end
                end
                ADD: begin
                    if (mp == '0) begin
                        state     <= DONE;
                        res_valid <= 1'b1;
                        result    <= acc;
                        ovf       <= ovf_r;
                    end else begin
                        if (mp[0]) begin
                            acc <= alu_y;
                            // a wrapped sum is smaller than the value it was added to
                            if (alu_y < acc) begin
                                ovf_r <= 1'b1;
                            end
                        end
                        state <= SHL;
                    end
                end
                SHL: begin
                    mc <= alu_y;
                    mp <= mp_shr;
                    // a bit shifted out of mc is lost only if later multiplier bits still need it
                    if (mc[WIDTH-1] && (mp_shr != '0)) begin
                        ovf_r <= 1'b1;
                    end
                    state <= ADD;
                end
                DONE: begin
                    if (res_ready) begin
                        state       <= IDLE;
                        res_valid   <= 1'b0;
                        result      <= '0;
                        ovf         <= 1'b0;
                        start_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb/tb_alu_mul_seq.sv - self-checking bench for alu_mul_seq with the shared ALU attached
module tb_alu_mul_seq;
    import cpu_pkg::*;

    localparam int W = 19;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         start_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] result;
    logic         ovf;
    logic         alu_own;
    logic [3:0]   alu_op;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [W-1:0] alu_y;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    alu_mul_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_ready(start_ready),
        .op_a(op_a), .op_b(op_b), .res_valid(res_valid), .res_ready(res_ready),
        .result(result), .ovf(ovf), .alu_own(alu_own), .alu_op(alu_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y)
    );

    cpu_alu u_alu (.op(alu_op), .a(alu_a), .b(alu_b), .y(alu_y));

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int top_bit(logic [W-1:0] b);
        int k = -1;
        for (int i = 0; i < W; i++) if (b[i]) k = i;
        return k;
    endfunction

    function automatic int exp_latency(logic [W-1:0] b);
        return (b == 0) ? 1 : 2 * (top_bit(b) + 1) + 1;
    endfunction

    // one SHL per examined multiplier bit plus one ADD per set bit
    function automatic int exp_own_cycles(logic [W-1:0] b);
        return (b == 0) ? 0 : top_bit(b) + 1 + $countones(b);
    endfunction

    typedef enum {PH_IDLE, PH_BUSY, PH_DONE} ph_e;
    ph_e             phase    = PH_IDLE;
    bit              rst_seen = 1'b1;
    bit              acc_seen = 1'b0;
    bit              rr_seen  = 1'b0;
    logic [W-1:0]    pa, pb;
    logic [W-1:0]    m_res;
    bit              m_ovf;
    int              m_lat, m_own, own_cnt, cnt;
    longint unsigned prod;

    // Transaction-level model: decisions sampled at one negedge take effect at the following posedge.
    always @(negedge clk) begin
        if (rst_seen) begin
            phase = PH_IDLE;
        end else begin
            case (phase)
                PH_IDLE: if (acc_seen) begin
                    prod    = longint'(pa) * longint'(pb);
                    m_res   = prod[W-1:0];
                    m_ovf   = (prod >> W) != 0;
                    m_lat   = exp_latency(pb);
                    m_own   = exp_own_cycles(pb);
                    cnt     = 0;
                    own_cnt = 0;
                    phase   = PH_BUSY;
                end
                PH_BUSY: begin
                    cnt++;
                    if (cnt == m_lat) begin
                        phase = PH_DONE;
                        if (chk_en) chk("own_cycles", own_cnt, m_own);
                    end
                end
                PH_DONE: if (rr_seen) phase = PH_IDLE;
                default: phase = PH_IDLE;
            endcase
        end
        if (chk_en) begin
            chk("start_ready", start_ready, phase == PH_IDLE);
            chk("res_valid", res_valid, phase == PH_DONE);
            chk("result", result, (phase == PH_DONE) ? m_res : '0);
            chk("ovf", ovf, (phase == PH_DONE) ? m_ovf : 1'b0);
            if (alu_own) begin
                chk("own_outside_busy", phase == PH_BUSY, 1);
                chk("own_opcode", (alu_op == ALU_ADD) || (alu_op == ALU_SHL), 1);
                own_cnt++;
            end else begin
                chk("alu_lines_idle", {alu_op, alu_a, alu_b}, 0);
            end
        end
        rst_seen = !rst_n;
        acc_seen = rst_n && start && (phase == PH_IDLE);
        rr_seen  = res_ready && (phase == PH_DONE);
        if (acc_seen) begin
            pa = op_a;
            pb = op_b;
        end
    end

    task automatic do_mul(input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                          input bit lit, input logic [W-1:0] er, input bit eo, input int el);
        int lat;
        @(posedge clk); #1;
        start = 1'b1; op_a = a; op_b = b; res_ready = (hold == 0);
        @(posedge clk); #1;
        start = 1'b0; op_a = W'($urandom); op_b = W'($urandom);
        lat = 0;
        while (!res_valid && lat < 60) begin
            start = lat[0];
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        if (!res_valid) chk("timeout_res_valid", 0, 1);
        if (lit) begin
            chk("lit_result", result, er);
            chk("lit_ovf", ovf, eo);
            chk("lit_latency", lat, el);
        end
        for (int i = 0; i < hold; i++) begin
            start = i[0];
            @(posedge clk); #1;
            chk("hold_valid", res_valid, 1);
            if (lit) chk("hold_result", result, er);
        end
        start = 1'b0; res_ready = 1'b1;
        @(posedge clk); #1;
        chk("idle_after_ack", start_ready, 1);
        chk("valid_drop_after_ack", res_valid, 0);
        res_ready = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; res_ready = 1'b0; op_a = '0; op_b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_start_ready", start_ready, 1);
        chk("reset_res_valid", res_valid, 0);
        chk("reset_alu_own", alu_own, 0);
        chk("reset_result", result, 0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        do_mul(19'd3,       19'd5,       0,  1, 19'd15,    1'b0, 7);
        do_mul(19'h40000,   19'd2,       0,  1, 19'h00000, 1'b1, 5);
        do_mul(19'h7FFFF,   19'h7FFFF,   0,  1, 19'h00001, 1'b1, 39);
        do_mul(19'h12345,   19'd0,       0,  1, 19'd0,     1'b0, 1);
        do_mul(19'd0,       19'h00081,   1,  1, 19'd0,     1'b0, 17);
        do_mul(19'd100,     19'd200,     10, 1, 19'd20000, 1'b0, 17);

        // reset while the sequencer is in SHL
        @(posedge clk); #1;
        start = 1'b1; op_a = 19'h7FFFF; op_b = 19'h7FFFF;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("mid_shl_own", alu_own, 1);
        chk("mid_shl_op", alu_op, ALU_SHL);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("post_rst_start_ready", start_ready, 1);
        chk("post_rst_res_valid", res_valid, 0);
        chk("post_rst_alu_own", alu_own, 0);
        do_mul(19'd6, 19'd7, 0, 1, 19'd42, 1'b0, 7);

        for (int t = 0; t < 10; t++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom);
            rb = W'($urandom) >> $urandom_range(0, 18);
            do_mul(ra, rb, $urandom_range(0, 3), 1'b0, '0, 1'b0, 0);
        end

        repeat (3) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
Multi-cycle unsigned 19x19 multiply sequencer. It time-shares the CPU's single combinational 19-bit ALU, using only the ADD and SHL operations, and runs a shift-add algorithm with early exit.
- While busy it drives the ALU operand/op lines and asserts alu_own.
- The top-level mux gives it the ALU whenever alu_own=1.
- Returns the low 19 bits of the product plus a sticky overflow flag.

Parameters:
WIDTH, 19, datapath width; must match the ALU width.
SHAMT_W, 5, width of the ALU shift-amount field (b[4:0]).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  synchronous active-low reset.
start  input  1  request valid; operands are presented with it.
start_ready  output  1  high only in IDLE; a request is accepted on the edge where start && start_ready.
op_a  input  WIDTH  multiplicand.
op_b  input  WIDTH  multiplier.
res_valid  output  1  result available (DONE state).
res_ready  input  1  consumer accepts the result.
result  output  WIDTH  product, low WIDTH bits.
ovf  output  1  product did not fit in WIDTH bits.
alu_own  output  1  sequencer owns the ALU this cycle.
alu_op  output  4  ALU opcode; 4'b0000 when not owning.
alu_a  output  WIDTH  ALU operand A; 0 when not owning.
alu_b  output  WIDTH  ALU operand B; 0 when not owning.
alu_y  input  WIDTH  combinational ALU result, used in the same cycle.

Behaviour:
Internal registers: acc, mc, mp, ovf_r, state.
- Reset (rst_n=0 at an edge) takes effect from any state, including mid-operation:
  - state=IDLE, acc=mc=mp=0, ovf_r=0.
  - Outputs: start_ready=1, res_valid=0, result=0, ovf=0, alu_own=0.
  - An in-flight result is discarded.
- IDLE: start_ready=1. On start, capture acc=0, mc=op_a, mp=op_b, ovf_r=0, then go to ADD.
- ADD:
  - If mp==0, go to DONE; alu_own=0.
  - Else if mp[0]=1: alu_own=1, alu_op=ADD(0000), alu_a=acc, alu_b=mc. Register acc<=alu_y. If alu_y<acc (unsigned wrap), set ovf_r. Go to SHL.
  - Else (mp[0]=0): alu_own=0, acc unchanged, go to SHL.
- SHL:
  - alu_own=1, alu_op=SHL(0110), alu_a=mc, alu_b=1.
  - Register mc<=alu_y and mp<=mp>>1 (local shift, no ALU).
  - If mc[WIDTH-1]=1 and (mp>>1)!=0, set ovf_r.
  - Go to ADD.
- DONE:
  - res_valid=1, result=acc, ovf=ovf_r; both held stable while res_ready=0.
  - On res_ready=1, go to IDLE. The next start can be accepted one cycle later; no same-cycle accept from DONE.
- Outputs result and ovf are 0 outside DONE.
- Latency, with k = index of the highest set bit of op_b: res_valid rises 2(k+1)+1 cycles after the accept edge. op_b=0 gives 1 cycle; the maximum is 39 cycles.
- op_a=0 with op_b!=0 still iterates, giving result 0 and ovf 0.
- start while not in IDLE is ignored; op_a and op_b are sampled only at the accept edge.
- The ALU is combinational: alu_y is consumed in the same cycle the operands are driven, with no extra wait state.

Decomposition:
- Shared package cpu_pkg holds:
  - ALU opcode constants ALU_ADD=4'b0000, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOT, ALU_SHL=4'b0110, ALU_SHR.
  - Data width constant 19.
  - State enum {IDLE, ADD, SHL, DONE} as 2-bit encoding.
- No sub-module. The bench instantiates the existing ALU and connects it directly to alu_op/alu_a/alu_b/alu_y.

Test Plan:
- op_a=3, op_b=5 with res_ready tied high -> result=15, ovf=0, res_valid rises 7 cycles after the accept edge, alu_own high in exactly 2 ADD + 3 SHL cycles.
- op_a=0x40000, op_b=2 -> result=0x00000, ovf=1, 5 cycles; op_a=0x7FFFF, op_b=0x7FFFF -> result=0x00001, ovf=1, 39 cycles.
- op_b=0, op_a=0x12345 -> result=0, ovf=0, res_valid 1 cycle after accept, alu_own never asserted.
- Backpressure: 100*200 with res_ready low for 10 cycles -> result=20000 and res_valid stable throughout; start pulses during busy/DONE are ignored; IDLE is re-entered the cycle after res_ready.
- rst_n low for one cycle during SHL of 0x7FFFF*0x7FFFF -> next cycle IDLE, res_valid=0, alu_own=0. A fresh 6*7 then yields 42, ovf=0.
- Back-to-back: 10 requests with random operands and random res_ready -> each result equals (a*b) mod 2^19, ovf equals (a*b >= 2^19), and alu_op/alu_a/alu_b are 0 whenever alu_own=0.
